// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder slice (two half-adder cells) walks the operands LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the sub port).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg, acc_reg, sum_reg;
    logic             cy_reg, cout_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] b_load;
    logic             cy_load;
    logic [1:0]       ha_x, ha_y, ha_s, ha_c;
    logic             s_bit, c_bit, last_bit;

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as A + ~B + 1; cout then reads as "no borrow".
    assign b_load  = sub ? ~b : b;
    assign cy_load = sub | cin;
`else
    assign b_load  = b;
    assign cy_load = cin;
`endif

    // Cell 0 adds the operand bits, cell 1 folds in the running carry.
    assign ha_x[0] = sa_reg[0];
    assign ha_y[0] = sb_reg[0];
    assign ha_x[1] = ha_s[0];
    assign ha_y[1] = cy_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ha
            assign ha_s[gi] = ha_x[gi] ^ ha_y[gi];
            assign ha_c[gi] = ha_x[gi] & ha_y[gi];
        end
    endgenerate

    assign s_bit    = ha_s[1];
    assign c_bit    = ha_c[0] | ha_c[1];
    assign last_bit = (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_reg   <= '0;
            sb_reg   <= '0;
            acc_reg  <= '0;
            sum_reg  <= '0;
            cy_reg   <= 1'b0;
            cout_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sa_reg  <= a;
                        sb_reg  <= b_load;
                        cy_reg  <= cy_load;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    sa_reg  <= sa_reg >> 1;
                    sb_reg  <= sb_reg >> 1;
                    acc_reg <= {s_bit, acc_reg[WIDTH-1:1]};
                    cy_reg  <= c_bit;
                    cnt_reg <= cnt_reg + CW'(1);
                    // The visible result only changes once the last bit is in.
                    if (last_bit) begin
                        sum_reg  <= {s_bit, acc_reg[WIDTH-1:1]};
                        cout_reg <= c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: driver pushes expected {cout,sum}, monitor pops on delivery.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_exp;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every delivered result is compared with the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%0h cout=%0b with nothing outstanding", sum, cout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_sum", 32'(sum), 32'(mon_exp[W-1:0]));
                check("result_cout", 32'(cout), 32'(mon_exp[W]));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic tsub, input logic push, input logic [W:0] expv,
                        input logic keep, output int t_drive);
        int n;
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        cin      = tc;
`ifdef SERIAL_ADD_SUB_EN
        sub      = tsub;
`endif
        in_valid = 1'b1;
        t_drive  = edges;
        if (push) exp_q.push_back(expv);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        if (tsub) ; // sub is only meaningful when subtract mode is built in
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s: out_valid never rose within %0d cycles", name, n);
        end
    endtask

    initial begin
        int t0;
        int busy_cnt;
        int n;
        int saw;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub       = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);

        // 0x3C + 0x5A: latency counted from the edge where the pair is presented.
        send(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1, 9'h096, 1'b0, t0);
        busy_cnt = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            n++;
        end
        check("latency_edges", 32'(edges - t0), W + 1);
        check("busy_cycles", 32'(busy_cnt), W);

        send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 9'h100, 1'b0, t0);
        send(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 9'h001, 1'b0, t0);
        send(8'h7F, 8'h01, 1'b1, 1'b0, 1'b1, 9'h081, 1'b0, t0);
        send(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 9'h100, 1'b0, t0);

        // Backpressure: result must hold while out_ready is low.
        wait_valid("drain_before_bp");
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 9'h100, 1'b0, t0);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum", 32'(sum), 32'h00);
            check("bp_cout", 32'(cout), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 1);
        check("bp_release_out_valid", 32'(out_valid), 0);

        // in_valid held high: the second pair waits for the first result.
        send(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 9'h033, 1'b1, t0);
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        exp_q.push_back(9'h077);
        check("b2b_blocked", 32'(in_ready), 0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        send(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 9'h0FE, 1'b0, t0);
        send(8'h07, 8'h05, 1'b1, 1'b1, 1'b1, 9'h102, 1'b0, t0);
        send(8'h07, 8'h05, 1'b1, 1'b0, 1'b1, 9'h00D, 1'b0, t0);
`endif

        // Reset at RUN bit 4 aborts the pair: nothing pushed, nothing expected.
        send(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        saw = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("abort_no_result", 32'(saw), 0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
